// File: rtl/mod3_counter_fsm.sv
// Free-running modulo-3 Moore counter: 0 -> 1 -> 2 -> 0 on every rising clk edge.
// Count, terminal-count flag and one-hot view are decoded from the state register only.
module mod3_counter_fsm (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] count,
    output logic       tc,
    output logic [2:0] state_onehot
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } state_e;

    // Plain vector so the unused 2'b11 code stays representable and recoverable.
    logic [1:0] state_q;
    logic [1:0] state_d;

    // NOTE: give every always_comb output a default first so no path infers a latch.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = S1;
            S1:      state_d = S2;
            default: state_d = S0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        count        = 2'd0;
        tc           = 1'b0;
        state_onehot = 3'b000;
        case (state_q)
            S0: begin
                state_onehot = 3'b001;
            end
            S1: begin
                count        = 2'd1;
                state_onehot = 3'b010;
            end
            S2: begin
                count        = 2'd2;
                tc           = 1'b1;
                state_onehot = 3'b100;
            end
            default: begin
                count        = 2'd0;
                state_onehot = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_mod3_counter_fsm.sv
// Self-checking bench for mod3_counter_fsm: directed reset/illegal-state cases plus
// randomized runs and async reset pulses checked against an edge-count model.
module tb_mod3_counter_fsm;

    logic       clk;
    logic       rst;
    logic [1:0] count;
    logic       tc;
    logic [2:0] state_onehot;

    int n_cmp;
    int n_err;
    int n_edges;   // rising edges seen since the last reset release (model state)
    int tc_seen;

    mod3_counter_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .count        (count),
        .tc           (tc),
        .state_onehot (state_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_count();
        return n_edges % 3;
    endfunction

    task automatic check_model(input string tag);
        int c;
        c = model_count();
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_tc"}, 32'(tc), (c == 2) ? 32'd1 : 32'd0);
        check({tag, "_onehot"}, 32'(state_onehot), 32'(1) << c);
    endtask

    task automatic check_reset_view(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_tc"}, 32'(tc), 32'd0);
        check({tag, "_onehot"}, 32'(state_onehot), 32'b001);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (!rst) n_edges++;
        check_model(tag);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        n_edges = 0;
        tc_seen = 0;
        rst     = 1'b1;

        // Power-up reset, including across the 5 ns edge.
        #1;
        check_reset_view("por");
        @(posedge clk);
        #1;
        check_reset_view("por_edge");

        // Release at 10 ns, then posedges 15..65 ns.
        @(negedge clk);
        rst     = 1'b0;
        n_edges = 0;
        for (int i = 0; i < 6; i++) step("freerun");

        // Advance to count == 2, then async reset between edges.
        for (int i = 0; i < 3 && model_count() != 2; i++) step("to_s2");
        check("pre_reset_tc", 32'(tc), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_view("async_mid");

        // Reset held over 5 edges.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_reset_view("rst_hold");
        end
        @(negedge clk);
        rst     = 1'b0;
        n_edges = 0;
        #1;
        check_reset_view("post_release");
        step("first_after_release");

        // Randomized: run a few edges or pulse reset inside the low clock phase.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #($urandom_range(1, 2));
                rst = 1'b1;
                #1;
                check_reset_view("rand_rst");
                rst     = 1'b0;
                n_edges = 0;
            end else begin
                int k;
                k = $urandom_range(1, 5);
                for (int j = 0; j < k; j++) step("rand_run");
            end
        end

        // Illegal-state recovery.
        @(negedge clk);
        force dut.state_q = 2'b11;
        #1;
        check("illegal_count", 32'(count), 32'd0);
        check("illegal_tc", 32'(tc), 32'd0);
        check("illegal_onehot", 32'(state_onehot), 32'b000);
        release dut.state_q;
        @(posedge clk);
        #1;
        n_edges = 0;
        check_model("recover");
        step("recover_next");

        // Long run: 300 edges after a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_view("long_rst");
        @(negedge clk);
        rst     = 1'b0;
        n_edges = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            n_edges++;
            if (count !== 2'(model_count())) begin
                check("long_count", 32'(count), 32'(model_count()));
            end
            if ($countones(state_onehot) != 1) begin
                check("long_onehot_pop", 32'($countones(state_onehot)), 32'd1);
            end
            if (tc === 1'b1) tc_seen++;
        end
        check("long_tc_total", 32'(tc_seen), 32'd100);
        check_model("long_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
